// File: rtl/bch_dec_ctrl.sv
// Frame sequencer for the BCH decoder front end: streams one codeword into the syndrome unit,
// classifies it from the odd syndromes and launches the key-equation solver only when needed.
module bch_dec_ctrl #(
  parameter int unsigned SYN_TIMEOUT = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [1:0] i_code,
  input  logic       i_in_valid,
  input  logic [7:0] i_in_data,
  output logic       o_in_ready,
  output logic [1:0] o_syn_code,
  output logic       o_syn_clear_and_wen,
  output logic       o_syn_wen,
  output logic [7:0] o_syn_data,
  input  logic       i_syn_odd_valid,
  input  logic       i_syn_all_valid,
  input  logic [9:0] i_syn_S1,
  input  logic [9:0] i_syn_S3,
  input  logic [9:0] i_syn_S5,
  input  logic [9:0] i_syn_S7,
  output logic       o_kes_start,
  input  logic       i_kes_done,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err_flag,
  output logic       o_timeout,
  output logic       o_cfg_err
);

  localparam int unsigned TmoW = $clog2(SYN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StWaitOdd, StWaitAll, StKes, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      byte_cnt_q, byte_cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            clean_q, clean_d;
  logic [1:0]      code_d;
  logic            err_d, timeout_d, cfg_err_d, kes_start_d, done_d;
  logic [6:0]      last_idx;
  logic            odd_clean, take, tmo_hit;

  always_comb begin
    unique case (o_syn_code)
      2'b00:   last_idx = 7'd7;
      2'b01:   last_idx = 7'd31;
      default: last_idx = 7'd127;
    endcase
  end

  // S5/S7 only carry information for the 1023/983 code.
  assign odd_clean = (i_syn_S1 == '0) && (i_syn_S3 == '0) &&
                     ((o_syn_code != 2'b10) || ((i_syn_S5 == '0) && (i_syn_S7 == '0)));
  assign take      = (state_q == StLoad) && i_in_valid;
  assign tmo_hit   = (tmo_q == TmoW'(SYN_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    clean_d     = clean_q;
    code_d      = o_syn_code;
    err_d       = o_err_flag;
    timeout_d   = o_timeout;
    cfg_err_d   = o_cfg_err;
    kes_start_d = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          code_d     = i_code;
          err_d      = 1'b0;
          timeout_d  = 1'b0;
          cfg_err_d  = 1'b0;
          byte_cnt_d = '0;
          if (i_code == 2'b11) begin
            cfg_err_d = 1'b1;
            state_d   = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (take) begin
          if (byte_cnt_q == last_idx) begin
            state_d = StWaitOdd;
            tmo_d   = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 7'd1;
          end
        end
      end
      StWaitOdd, StWaitAll: begin
        tmo_d = tmo_q + 1'b1;
        if ((state_q == StWaitOdd) && i_syn_odd_valid) begin
          clean_d = odd_clean;
          state_d = StWaitAll;
        end
        // An all-valid in the same cycle as odd-valid resolves with the fresh verdict.
        if (i_syn_all_valid && ((state_q == StWaitAll) || i_syn_odd_valid)) begin
          if (clean_d) begin
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            kes_start_d = 1'b1;
            err_d       = 1'b1;
            tmo_d       = '0;
            state_d     = StKes;
          end
        end else if (!((state_q == StWaitOdd) && i_syn_odd_valid) && tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StKes: begin
        tmo_d = tmo_q + 1'b1;
        if (i_kes_done) begin
          state_d = StDone;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q             <= StIdle;
      byte_cnt_q          <= '0;
      tmo_q               <= '0;
      clean_q             <= 1'b0;
      o_syn_code          <= 2'b00;
      o_syn_data          <= 8'h00;
      o_syn_wen           <= 1'b0;
      o_syn_clear_and_wen <= 1'b0;
      o_in_ready          <= 1'b0;
      o_busy              <= 1'b0;
      o_kes_start         <= 1'b0;
      o_done              <= 1'b0;
      o_err_flag          <= 1'b0;
      o_timeout           <= 1'b0;
      o_cfg_err           <= 1'b0;
    end else begin
      state_q             <= state_d;
      byte_cnt_q          <= byte_cnt_d;
      tmo_q               <= tmo_d;
      clean_q             <= clean_d;
      o_syn_code          <= code_d;
      o_syn_wen           <= take;
      o_syn_clear_and_wen <= take && (byte_cnt_q == 7'd0);
      if (take) o_syn_data <= i_in_data;
      o_in_ready          <= (state_d == StLoad);
      o_busy              <= (state_d != StIdle);
      o_kes_start         <= kes_start_d;
      o_done              <= done_d;
      o_err_flag          <= err_d;
      o_timeout           <= timeout_d;
      o_cfg_err           <= cfg_err_d;
    end
  end

endmodule
